// File: rtl/regfile_stack_param.sv
// regfile_stack_param: parametrised LIFO register file with registered
// top-of-stack and random read ports, occupancy, full/empty and sticky
// overflow/underflow flags.
module regfile_stack_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              top_re,
    output logic [DATA_W-1:0] top_data,
    output logic              top_valid,
    input  logic              ran_re,
    input  logic [ADDR_W-1:0] ran_addr,
    output logic [DATA_W-1:0] ran_data,
    output logic              ran_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    // Storage: one write port, two read ports, no reset so it maps to RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              underflow_q;
    logic              underflow_d;
    logic              is_full;
    logic              is_empty;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] top_idx;
    logic              top_hit;
    logic              ran_hit;

    // Occupancy decodes; the top entry lives one below the count.
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == CNT_W'(0));
    assign top_idx  = ADDR_W'(count_q - CNT_W'(1));
    assign top_hit  = top_re && !is_empty;
    assign ran_hit  = ran_re && (CNT_W'(ran_addr) < count_q);

    // Next-state for count, sticky flags and the memory write port.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_addr     = ADDR_W'(count_q);

        if (clr) begin
            count_d     = CNT_W'(0);
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (push && pop && !is_empty) begin
            // Replace-top never changes occupancy, so it is legal even when full.
            wr_en   = 1'b1;
            wr_addr = top_idx;
        end else if (push) begin
            // Push alone, or push+pop on an empty stack.
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_addr = ADDR_W'(count_q);
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Stack state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= CNT_W'(0);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write; a write racing an asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && rst_n) begin
            mem[wr_addr] <= push_data;
        end
    end

    // Top-of-stack read port, sampling pre-edge contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_data  <= '0;
            top_valid <= 1'b0;
        end else if (clr) begin
            top_data  <= '0;
            top_valid <= 1'b0;
        end else begin
            top_valid <= top_hit;
            top_data  <= top_hit ? mem[top_idx] : '0;
        end
    end

    // Random read port; indices at or above the count read as invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ran_data  <= '0;
            ran_valid <= 1'b0;
        end else if (clr) begin
            ran_data  <= '0;
            ran_valid <= 1'b0;
        end else begin
            ran_valid <= ran_hit;
            ran_data  <= ran_hit ? mem[ran_addr] : '0;
        end
    end

    assign count     = count_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/regfile_stack_param.md
Name: regfile_stack_param

Overview:
- Parametrised successor to the append-only register file used by the recursion state machines.
- Stores a LIFO of DATA_W-bit words with configurable DEPTH.
- Supports push, pop, and replace-top (push+pop in the same cycle).
- Provides a registered top-of-stack read port and a registered random read port, with valid flags, occupancy, full/empty and sticky error flags, so the controlling FSM can unwind recursion levels instead of only appending.

Parameters:
- DATA_W, 32, width of each stored word.
- DEPTH, 4096, number of entries; any value ≥ 2, not required to be a power of two.
- ADDR_W, $clog2(DEPTH), width of random read addresses.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- clr  in  1  synchronous clear of stack state.
- push  in  1  write push_data at current top+1.
- push_data  in  DATA_W  data to push.
- pop  in  1  remove top entry.
- top_re  in  1  request a top-of-stack read.
- top_data  out  DATA_W  registered top-of-stack data.
- top_valid  out  1  top_data is valid.
- ran_re  in  1  request a random read.
- ran_addr  in  ADDR_W  random read index (0 = bottom of stack).
- ran_data  out  DATA_W  registered random read data.
- ran_valid  out  1  ran_data is valid.
- count  out  CNT_W  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: push rejected while full.
- underflow  out  1  sticky: pop rejected while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, so empty=1 and full=0.
  - overflow=0, underflow=0.
  - top_data=0, top_valid=0, ran_data=0, ran_valid=0.
  - Memory contents are not reset.
- clr (synchronous) has priority over push, pop and reads.
  - Next cycle: count=0, both sticky flags=0, all read outputs and valids=0.
  - Memory is untouched.
- Stack update, evaluated each edge when clr=0, using pre-edge count C:
  - push only, C<DEPTH: mem[C] <= push_data; count <= C+1.
  - push only, C==DEPTH: no write, count unchanged, overflow <= 1.
  - pop only, C>0: count <= C-1; the entry is not cleared.
  - pop only, C==0: count unchanged, underflow <= 1.
  - push+pop, C>0: replace top; mem[C-1] <= push_data; count unchanged; no flags set, including when full.
  - push+pop, C==0: treated as push only; no underflow.
- count, full and empty are registered state. full and empty decode combinationally from count.
- Read latency is one cycle. Reads sample pre-edge state, so a read in the same cycle as a push, pop or replace returns the old contents.
- Top read: on the edge after top_re=1:
  - If C>0: top_valid=1, top_data=mem[C-1].
  - If C==0: top_valid=0, top_data=0.
  - If top_re=0: top_valid=0, top_data=0.
- Random read: on the edge after ran_re=1:
  - If ran_addr<C: ran_valid=1, ran_data=mem[ran_addr].
  - If ran_addr≥C (this includes ran_addr≥DEPTH): ran_valid=0, ran_data=0.
  - If ran_re=0: ran_valid=0, ran_data=0.
- Both read ports operate independently and may be active in the same cycle.
- Sticky flags are cleared only by rst_n or clr.
- rst_n asserted mid-operation: everything returns to reset values immediately, and any in-flight write is discarded.
- Storage is a single memory with one synchronous write port and two synchronous read ports; it must infer block or distributed RAM.

Test Plan (DEPTH=8, DATA_W=32):
- After reset, push 0x11, 0x22, 0x33 on consecutive cycles, then top_re → top_data=0x33, top_valid=1, count=3, empty=0.
- Random reads: ran_addr=1 → ran_data=0x22, ran_valid=1. ran_addr=3 → ran_data=0, ran_valid=0.
- Pop while top_re is asserted in the same cycle: the next cycle shows top_data=0x33 (pre-pop value) and count=2. A following top_re gives top_data=0x22.
- Push+pop with push_data=0xAA at count=2 → count stays 2; top read gives 0xAA; random read at addr 0 gives 0x11.
- Push 0x0 to 0x7 from empty, so full=1 at count=8. A 9th push gives overflow=1 and count=8, with top still 0x7. Push+pop 0xBB while full → top=0xBB and overflow stays 1 without being re-triggered by this operation.
- Pop at count=0 → underflow=1, count=0. Then clr → underflow=0, overflow=0, top_valid=0. Then assert rst_n=0 mid-push → count=0 immediately and the push is discarded.
